// File: rtl/sad_min_search_if.sv
// Row-beat input bus feeding the SAD minimum search.
// start pulse, ad_valid qualifier and packed per-PE AD bytes.
interface sad_min_search_if #(
  parameter int NPE = 16
);
  logic             start;
  logic             ad_valid;
  logic [NPE*8-1:0] ad;

  modport master (
    output start,
    output ad_valid,
    output ad
  );

  modport slave (
    input start,
    input ad_valid,
    input ad
  );
endinterface

// File: rtl/sad_min_search.sv
// Accumulates per-candidate SAD from PE row beats and tracks the min SAD/mv.
// Ports: clk, rst_n, bus (start/ad_valid/ad), busy, cand_*, best_*, done.
module sad_min_search #(
  parameter int NPE  = 16,
  parameter int ROWS = 16,
  parameter int SR   = 8,
  parameter int SADW = 16,
  parameter int MVW  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sad_min_search_if.slave       bus,
  output logic                  busy,
  output logic                  cand_valid,
  output logic [SADW-1:0]       cand_sad,
  output logic [SADW-1:0]       best_sad,
  output logic signed [MVW-1:0] best_mvx,
  output logic signed [MVW-1:0] best_mvy,
  output logic                  done
);

  localparam int RSW = 8 + $clog2(NPE);
  localparam int RW  = $clog2(ROWS);

  localparam logic signed [MVW-1:0] MV_MIN = MVW'(-SR);
  localparam logic signed [MVW-1:0] MV_MAX = MVW'(SR - 1);
  localparam logic signed [MVW-1:0] MV_ONE = MVW'(1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(ROWS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state_q, state_d;

  logic [RW-1:0]         row_q;
  logic signed [MVW-1:0] mvx_q, mvy_q;

  logic [RSW-1:0]        s1_sum_q;
  logic                  s1_v_q, s1_first_q, s1_last_q;
  logic                  s1_c0_q, s1_fin_q;
  logic signed [MVW-1:0] s1_mvx_q, s1_mvy_q;

  logic [SADW-1:0]       acc_q, acc_d;
  logic                  cv_q, c0_q, cfin_q;
  logic [SADW-1:0]       csad_q;
  logic signed [MVW-1:0] cmvx_q, cmvy_q;

  logic [SADW-1:0]       bsad_q;
  logic signed [MVW-1:0] bmvx_q, bmvy_q;

  logic [RSW-1:0] row_sum;
  logic           go, accept, last_row, last_x, last_y;
  logic           fin_beat, take;

  assign go       = (state_q == IDLE) && bus.start;
  assign accept   = (state_q == RUN) && bus.ad_valid;
  assign last_row = (row_q == ROW_LAST);
  assign last_x   = (mvx_q == MV_MAX);
  assign last_y   = (mvy_q == MV_MAX);
  assign fin_beat = accept && last_row && last_x && last_y;

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < NPE; i++) begin
      row_sum = row_sum + RSW'(bus.ad[8*i +: 8]);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN:   if (fin_beat) state_d = FLUSH;
      FLUSH: if (cv_q && cfin_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Row counter plus split x/y candidate counter in raster order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      mvx_q <= '0;
      mvy_q <= '0;
    end else if (go) begin
      row_q <= '0;
      mvx_q <= MV_MIN;
      mvy_q <= MV_MIN;
    end else if (accept) begin
      row_q <= last_row ? '0 : row_q + RW'(1);
      if (last_row) begin
        if (last_x) begin
          mvx_q <= MV_MIN;
          mvy_q <= mvy_q + MV_ONE;
        end else begin
          mvx_q <= mvx_q + MV_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_sum_q   <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_c0_q    <= 1'b0;
      s1_fin_q   <= 1'b0;
      s1_mvx_q   <= '0;
      s1_mvy_q   <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_sum_q   <= row_sum;
        s1_first_q <= (row_q == '0);
        s1_last_q  <= last_row;
        s1_c0_q    <= (mvx_q == MV_MIN) && (mvy_q == MV_MIN);
        s1_fin_q   <= last_x && last_y;
        s1_mvx_q   <= mvx_q;
        s1_mvy_q   <= mvy_q;
      end
    end
  end

  // Row 0 restarts the sum so consecutive candidates never leak.
  assign acc_d = s1_first_q ? SADW'(s1_sum_q)
                            : acc_q + SADW'(s1_sum_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cv_q   <= 1'b0;
      csad_q <= '0;
      c0_q   <= 1'b0;
      cfin_q <= 1'b0;
      cmvx_q <= '0;
      cmvy_q <= '0;
    end else begin
      cv_q <= s1_v_q && s1_last_q;
      if (s1_v_q) acc_q <= acc_d;
      if (s1_v_q && s1_last_q) begin
        csad_q <= acc_d;
        c0_q   <= s1_c0_q;
        cfin_q <= s1_fin_q;
        cmvx_q <= s1_mvx_q;
        cmvy_q <= s1_mvy_q;
      end
    end
  end

  // Strict less-than keeps the earliest raster candidate on ties.
  assign take = cv_q && (c0_q || (csad_q < bsad_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsad_q <= '1;
      bmvx_q <= '0;
      bmvy_q <= '0;
    end else if (go) begin
      bsad_q <= '1;
      bmvx_q <= '0;
      bmvy_q <= '0;
    end else if (take) begin
      bsad_q <= csad_q;
      bmvx_q <= cmvx_q;
      bmvy_q <= cmvy_q;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == FLUSH);
  assign done       = (state_q == DONE);
  assign cand_valid = cv_q;
  assign cand_sad   = csad_q;
  assign best_sad   = bsad_q;
  assign best_mvx   = bmvx_q;
  assign best_mvy   = bmvy_q;

endmodule

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Downstream consumer of the PE systolic array in the full-search motion estimation processor.
- Each accepted beat carries one absolute-difference (AD) byte per PE, covering one block row of one candidate.
- Reduces each beat to a row sum and accumulates ROWS row sums into one candidate SAD.
- Tracks the minimum SAD and its motion vector over all (2*SR)^2 candidates, then reports the winner with a done pulse.

Parameters:
- NPE, 16, number of PE AD lanes per beat (block width).
- ROWS, 16, beats per candidate (block height).
- SR, 8, search range; candidate mv components run from -SR to SR-1.
- SADW, 16, SAD width; must be >= 8+clog2(NPE)+clog2(ROWS).
- MVW, 5, signed mv component width; must be >= clog2(2*SR)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a search; honoured only in IDLE.
- ad_valid  in  1  ad carries a valid row beat this cycle.
- ad  in  NPE*8  lane i = ad[8i+7:8i], unsigned AD from PE i.
- busy  out  1  high in RUN and FLUSH.
- cand_valid  out  1  one-cycle pulse; cand_sad holds a completed candidate SAD.
- cand_sad  out  SADW  most recent candidate SAD.
- best_sad  out  SADW  minimum SAD so far.
- best_mvx  out  MVW  signed x of best candidate.
- best_mvy  out  MVW  signed y of best candidate.
- done  out  1  one-cycle pulse; best_* are final.

Behaviour:
- Reset values (async): state IDLE; busy=0; cand_valid=0; cand_sad=0; best_sad=all ones; best_mvx=0; best_mvy=0; done=0; all counters and pipeline valids=0.
- FSM states:
  - IDLE: start -> RUN. On that edge: clear the row counter and candidate counter, set best_sad to all ones and best_mv to 0.
  - RUN: each cycle with ad_valid=1 is an accepted beat.
    - Row counter counts 0..ROWS-1, then wraps.
    - On the beat with row==ROWS-1, the candidate counter increments.
    - On the last beat of candidate (2*SR)^2-1 -> FLUSH; no further beats are accepted.
  - FLUSH: wait until the final compare completes -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
- Ignored inputs:
  - ad_valid in IDLE, FLUSH or DONE has no effect.
  - start in RUN, FLUSH or DONE has no effect.
- Candidate order is raster: mvx steps -SR..SR-1 in the inner loop, mvy steps -SR..SR-1 in the outer loop. Candidate k has mvx = (k mod 2SR) - SR and mvy = (k div 2SR) - SR.
- Pipeline (T = edge accepting a beat):
  - T: stage-1 register loads the unsigned sum of NPE lanes (width 8+clog2(NPE)), plus its valid, last-row flag and candidate mv.
  - T+1: stage-2 accumulator loads row_sum on row 0 of a candidate, otherwise acc+row_sum.
    - If the last-row flag is set, cand_sad loads the full candidate total and cand_valid=1 for one cycle, with mv tagged alongside.
  - T+2: compare stage. best_sad, best_mvx and best_mvy load the candidate when it is candidate 0 (unconditional) or when cand_sad < best_sad.
    - Strict less-than: on a tie, the earliest candidate in raster order wins.
  - For the final candidate, done=1 on the cycle following the T+2 update, i.e. in DONE.
- Arithmetic: all sums are unsigned with no saturation. The worst case 255*NPE*ROWS fits in SADW by the parameter constraint.
- Gapped ad_valid: the pipeline advances only on valid data. Results are independent of bubbles.
- Back-to-back beats across a candidate boundary: row 0 of the next candidate must not add the previous accumulator.
- Reset mid-operation: everything returns to reset values immediately. A new start is required.
- best_* hold their last values in IDLE until the next start clears them.

Test Plan:
1. start, then 4096 consecutive beats with all ad=0 -> 256 cand_valid pulses, each cand_sad=0. done 3 cycles after the last beat. best_sad=0, best_mv=(-8,-8) (tie rule).
2. All lanes=1 except candidate 37 with all lanes=0 -> cand_sad=256 for the others. best_sad=0, best_mvx=-3, best_mvy=-6.
3. All lanes=255 -> every cand_sad=65280, no overflow. best_sad=65280, best_mv=(-8,-8).
4. Scenario 2 with ad_valid toggling 1/0 every cycle -> identical cand_sad sequence and identical best_* values. busy stays high until DONE.
5. Assert rst_n low after 100 beats -> all outputs at reset values next sample. start again with scenario 2 data -> correct result.
6. Protocol checks:
   - ad_valid pulses in IDLE -> no cand_valid.
   - A second start during RUN -> ignored; the search completes with 256 candidates.
   - Extra ad_valid during FLUSH -> no extra cand_valid.
